avalon_seg7_multi: RTL
======================

// Module: avalon_seg7_multi
// PURPOSE
//  Avalon-MM slave for a bank of seven-segment digits, with per-digit blanking and blink.
//  Replaces the raw 32-bit PIO-to-HEX path: software writes packed hex nibbles and the
//  block does the decode. Sits on the lightweight bus beside the other PIO slaves;
//  seg_out drives the board HEX pins directly.
// PARAMETERS
//  NUM_DIGITS    8         digits driven, 1..8; nibble i -> seg_out[7*i+6:7*i]
//  ACTIVE_LOW    1         1: segment on = 0 (DE2 HEX); 0: segment on = 1
//  PERIOD_W      26        width of blink period register/counter
//  PERIOD_RST    25000000  reset value of PERIOD (0.5 s half-period at 50 MHz)
// PORTS
//  clk         in   1               system clock
//  reset       in   1               asynchronous, active-high reset
//  address     in   2               word address: 0 DATA, 1 ENABLE, 2 BLINK, 3 PERIOD
//  chipselect  in   1               slave select
//  write_n     in   1               active-low write strobe
//  writedata   in   32              write data
//  readdata    out  32              read data, zero wait states, combinational
//  seg_out     out  7*NUM_DIGITS    segment outputs {g..a} per digit
// BEHAVIOUR
//  Reset: asynchronous, active-high; one clock domain (clk).
//  Write: chipselect & ~write_n at a clk edge updates the addressed register.
//  Registers (N = NUM_DIGITS):
//   DATA   [4N-1:0] hex nibbles; reset 0
//   ENABLE [N-1:0]  1 = digit shown; reset all ones
//   BLINK  [N-1:0]  1 = digit blinks; reset 0
//   PERIOD [PERIOD_W-1:0] blink half-period in clk cycles; reset PERIOD_RST
//  Register bits above each field are ignored on write and read as 0.
//  Read: readdata = addressed register, zero-extended; no side effects.
//  Blink timer:
//   - cnt counts 0..PERIOD-1, then wraps to 0 and toggles phase.
//   - phase resets to 1 (visible).
//   - A write to PERIOD clears cnt to 0 and sets phase to 1 on that same edge.
//   - PERIOD == 0: cnt is held at 0 and phase is held at 1 (blink disabled).
//  Digit i is lit when ENABLE[i] & (~BLINK[i] | phase).
//   - Lit: standard hex decode of DATA nibble i (0-9, A, b, C, d, E, F).
//   - Unlit: all segments off.
//  Output polarity: active-high pattern, inverted when ACTIVE_LOW = 1.
//   Blank = 7'h7F when ACTIVE_LOW = 1, 7'h00 otherwise.
//  Latency: seg_out is registered.
//   - A register write captured at edge E is visible on seg_out after edge E+1.
//   - A phase toggle at edge E is visible on seg_out after edge E+1.
//  Reset value of seg_out: digit 0 decoded from 0 for every digit (7'h40 each when ACTIVE_LOW = 1).
//  readdata has no reset dependency beyond the register reset values.
//  Simultaneous events: a phase toggle and a register write on the same edge both take effect.
//   A PERIOD write overrides the toggle.
//  Reset asserted mid-blink: cnt, phase and all registers return to reset values immediately.
// TESTING
//  1 Reset, N=8, ACTIVE_LOW=1 -> seg_out = 8 x 7'h40; readdata @1 = 0xFF, @3 = 25000000.
//  2 Write DATA=0x0123ABCF -> after 2 edges: digit0 = F (7'h0E), digit4 = 3 (7'h30),
//    digit7 = 0 (7'h40); read @0 returns 0x0123ABCF.
//  3 Write ENABLE=0x0F -> digits 4..7 = 7'h7F; digits 0..3 keep their decoded values.
//  4 Write PERIOD=4, BLINK=0x01 -> digit0 alternates lit/blank every 4 clk;
//    writing PERIOD=0 mid-blank -> digit0 lit from the next edge+1 and stays lit.
//  5 N=4, ACTIVE_LOW=0: write DATA=0xFFFF1234 -> read @0 = 0x1234; seg_out digit0 = 7'h66.
//  6 Assert reset during blink with PERIOD=3 -> all registers and seg_out return to reset values
//    asynchronously; blink restarts visible.

Source files
------------

// File: rtl/avalon_seg7_multi_if.sv
// Avalon-MM slave bus bundle for the seven-segment display block.
interface avalon_seg7_multi_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );
endinterface

// File: rtl/avalon_seg7_multi.sv
// Avalon-MM seven-segment driver: packed hex nibbles in, decoded segments out,
// with per-digit enable and blink driven by a programmable half-period timer.
module avalon_seg7_multi #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned PERIOD_W   = 26,
  parameter int unsigned PERIOD_RST = 25000000
) (
  input  logic                      clk,
  input  logic                      reset,
  avalon_seg7_multi_if.slave        avs,
  output logic [7*NUM_DIGITS-1:0]   seg_out
);

  localparam int unsigned DataW = 4 * NUM_DIGITS;
  localparam int unsigned SegW  = 7 * NUM_DIGITS;

  // Every digit showing "0" at reset, in output polarity.
  localparam logic [6:0]      SegZero = ACTIVE_LOW ? 7'h40 : 7'h3F;
  localparam logic [SegW-1:0] SegRst  = {NUM_DIGITS{SegZero}};

  localparam logic [1:0] AddrData   = 2'd0;
  localparam logic [1:0] AddrEnable = 2'd1;
  localparam logic [1:0] AddrBlink  = 2'd2;
  localparam logic [1:0] AddrPeriod = 2'd3;

  logic [DataW-1:0]      data_q, data_d;
  logic [NUM_DIGITS-1:0] enable_q, enable_d;
  logic [NUM_DIGITS-1:0] blink_q, blink_d;
  logic [PERIOD_W-1:0]   period_q, period_d;
  logic [PERIOD_W-1:0]   cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [SegW-1:0]       seg_q, seg_d;

  logic        wr_en;
  logic        period_wr;
  logic [31:0] rdata;
  logic        unused_wd;

  assign wr_en     = avs.chipselect & ~avs.write_n;
  assign period_wr = wr_en & (avs.address == AddrPeriod);
  // Upper write-data bits beyond each field are deliberately dropped.
  assign unused_wd = ^avs.writedata;

  // Active-high {g..a} hex decode.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h3F;
      4'h1:    pat = 7'h06;
      4'h2:    pat = 7'h5B;
      4'h3:    pat = 7'h4F;
      4'h4:    pat = 7'h66;
      4'h5:    pat = 7'h6D;
      4'h6:    pat = 7'h7D;
      4'h7:    pat = 7'h07;
      4'h8:    pat = 7'h7F;
      4'h9:    pat = 7'h6F;
      4'hA:    pat = 7'h77;
      4'hB:    pat = 7'h7C;
      4'hC:    pat = 7'h39;
      4'hD:    pat = 7'h5E;
      4'hE:    pat = 7'h79;
      default: pat = 7'h71;
    endcase
    return pat;
  endfunction

  // Register file write decode.
  always_comb begin
    data_d   = data_q;
    enable_d = enable_q;
    blink_d  = blink_q;
    period_d = period_q;
    if (wr_en) begin
      case (avs.address)
        AddrData:   data_d   = avs.writedata[DataW-1:0];
        AddrEnable: enable_d = avs.writedata[NUM_DIGITS-1:0];
        AddrBlink:  blink_d  = avs.writedata[NUM_DIGITS-1:0];
        default:    period_d = avs.writedata[PERIOD_W-1:0];
      endcase
    end
  end

  // Blink timer: half-period counter; a PERIOD write restarts it visible.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (period_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q >= period_q - PERIOD_W'(1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + PERIOD_W'(1);
    end
    if (period_wr) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end
  end

  // Per-digit decode, blanking and polarity; registered for clean pin timing.
  always_comb begin
    seg_d = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      logic       lit;
      logic [6:0] pat;
      lit = enable_q[i] & (~blink_q[i] | phase_q);
      pat = lit ? hex7(data_q[4*i +: 4]) : 7'h00;
      seg_d[7*i +: 7] = ACTIVE_LOW ? ~pat : pat;
    end
  end

  // Zero-wait-state read mux, zero-extended.
  always_comb begin
    rdata = '0;
    case (avs.address)
      AddrData:   rdata[DataW-1:0]      = data_q;
      AddrEnable: rdata[NUM_DIGITS-1:0] = enable_q;
      AddrBlink:  rdata[NUM_DIGITS-1:0] = blink_q;
      default:    rdata[PERIOD_W-1:0]   = period_q;
    endcase
  end

  assign avs.readdata = rdata;
  assign seg_out      = seg_q;

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q   <= '0;
      enable_q <= '1;
      blink_q  <= '0;
      period_q <= PERIOD_W'(PERIOD_RST);
      cnt_q    <= '0;
      phase_q  <= 1'b1;
      seg_q    <= SegRst;
    end else begin
      data_q   <= data_d;
      enable_q <= enable_d;
      blink_q  <= blink_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      phase_q  <= phase_d;
      seg_q    <= seg_d;
    end
  end

endmodule
